// File: rtl/mask_estimator_if.sv
// Handshake bundle for the mask estimator: input pixel triple on the s side,
// the mask result and its status flags on the m side.
interface mask_estimator_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] pixel_t;
  logic [7:0] pixel_t1;
  logic [7:0] pixel_blend;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] mask_out;
  logic       degenerate;
  logic       clamped;

  modport slave (
    input  s_valid, pixel_t, pixel_t1, pixel_blend, m_ready,
    output s_ready, m_valid, mask_out, degenerate, clamped
  );

  modport master (
    output s_valid, pixel_t, pixel_t1, pixel_blend, m_ready,
    input  s_ready, m_valid, mask_out, degenerate, clamped
  );
endinterface

// File: rtl/mask_estimator.sv
// Recovers the blend mask from a blended pixel and its two sources with a restoring divider.
// Result valid 2+16/ITER_PER_CYCLE cycles after accept (2 for special cases); held until m_ready.
module mask_estimator #(
  parameter int ITER_PER_CYCLE = 1,
  parameter int ROUND          = 1
) (
  input logic             clk,
  input logic             rst,
  mask_estimator_if.slave bus
);
  localparam int STEPS = 16 / ITER_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  pt_q, pt1_q, blend_q, den_q;
  logic [8:0]  rem_q, rem_nxt;
  logic [15:0] quo_q, quo_nxt;
  logic [4:0]  cnt_q;
  logic        m_valid_q;
  logic [7:0]  mask_q;
  logic        degen_q, clamp_q;

  logic [7:0]        den_c;
  logic signed [8:0] num_c;
  logic [15:0]       dividend_c;
  logic              special_c;
  logic [7:0]        special_mask_c;
  logic              special_degen_c, special_clamp_c;

  // Orient the pair so den is non-negative; num < 0 or num > den means blend is out of range.
  always_comb begin
    if (pt_q >= pt1_q) begin
      den_c = pt_q - pt1_q;
      num_c = $signed({1'b0, blend_q}) - $signed({1'b0, pt1_q});
    end else begin
      den_c = pt1_q - pt_q;
      num_c = $signed({1'b0, pt1_q}) - $signed({1'b0, blend_q});
    end
    dividend_c = {8'd0, num_c[7:0]} * 16'd255
               + ((ROUND != 0) ? {9'd0, den_c[7:1]} : 16'd0);
    special_c       = 1'b1;
    special_mask_c  = 8'd255;
    special_degen_c = 1'b0;
    special_clamp_c = 1'b0;
    if (den_c == 8'd0) begin
      special_degen_c = 1'b1;
    end else if (num_c[8]) begin
      special_mask_c  = 8'd0;
      special_clamp_c = 1'b1;
    end else if (num_c > $signed({1'b0, den_c})) begin
      special_clamp_c = 1'b1;
    end else if (num_c != $signed({1'b0, den_c})) begin
      special_c = 1'b0;
    end
  end

  always_comb begin
    rem_nxt = rem_q;
    quo_nxt = quo_q;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      rem_nxt = {rem_nxt[7:0], quo_nxt[15]};
      quo_nxt = {quo_nxt[14:0], 1'b0};
      if (rem_nxt >= {1'b0, den_q}) begin
        rem_nxt    = rem_nxt - {1'b0, den_q};
        quo_nxt[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.s_valid) state_nxt = PREP;
      PREP:    state_nxt = special_c ? DONE : DIV;
      DIV:     if (cnt_q == 5'd0) state_nxt = DONE;
      DONE:    if (m_valid_q && bus.m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pt_q      <= 8'd0;
      pt1_q     <= 8'd0;
      blend_q   <= 8'd0;
      den_q     <= 8'd0;
      rem_q     <= 9'd0;
      quo_q     <= 16'd0;
      cnt_q     <= 5'd0;
      m_valid_q <= 1'b0;
      mask_q    <= 8'd0;
      degen_q   <= 1'b0;
      clamp_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.s_valid) begin
            pt_q    <= bus.pixel_t;
            pt1_q   <= bus.pixel_t1;
            blend_q <= bus.pixel_blend;
          end
        end
        PREP: begin
          den_q <= den_c;
          rem_q <= 9'd0;
          quo_q <= dividend_c;
          cnt_q <= 5'(STEPS - 1);
          if (special_c) begin
            mask_q  <= special_mask_c;
            degen_q <= special_degen_c;
            clamp_q <= special_clamp_c;
          end
        end
        DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            mask_q  <= quo_nxt[7:0];
            degen_q <= 1'b0;
            clamp_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
      // Valid trails entry into DONE by one cycle so the flags are settled before it is offered.
      m_valid_q <= (state == DONE) && !(m_valid_q && bus.m_ready);
    end
  end

  assign bus.s_ready    = (state == IDLE);
  assign bus.m_valid    = m_valid_q;
  assign bus.mask_out   = mask_q;
  assign bus.degenerate = degen_q;
  assign bus.clamped    = clamp_q;
endmodule

// File: tb/tb_mask_estimator.sv
// Directed checks of mask_estimator plus a parameter sweep over ITER_PER_CYCLE and ROUND.
module tb_mask_estimator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  mask_estimator_if bus();
  mask_estimator dut (.clk(clk), .rst(rst), .bus(bus));

  logic       sw_valid, sw_mready;
  logic [7:0] sw_pt, sw_pt1, sw_bl;
  logic [5:0] sw_mvld, sw_deg, sw_clp;
  logic [7:0] sw_mask [6];

  function automatic int sw_iter(input int g);
    return (g < 2) ? 1 : (g < 4) ? 4 : 16;
  endfunction

  for (genvar g = 0; g < 6; g++) begin : sw
    localparam int IT = (g < 2) ? 1 : (g < 4) ? 4 : 16;
    localparam int RD = g % 2;
    mask_estimator_if sif();
    assign sif.s_valid     = sw_valid;
    assign sif.pixel_t     = sw_pt;
    assign sif.pixel_t1    = sw_pt1;
    assign sif.pixel_blend = sw_bl;
    assign sif.m_ready     = sw_mready;
    assign sw_mvld[g]      = sif.m_valid;
    assign sw_deg[g]       = sif.degenerate;
    assign sw_clp[g]       = sif.clamped;
    assign sw_mask[g]      = sif.mask_out;
    mask_estimator #(.ITER_PER_CYCLE(IT), .ROUND(RD)) u_dut (.clk(clk), .rst(rst), .bus(sif));
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_tx(input int pt, input int pt1, input int bl);
    int w;
    w = 0;
    while (!bus.s_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("s_ready_before_accept", int'(bus.s_ready), 1);
    bus.pixel_t     = 8'(pt);
    bus.pixel_t1    = 8'(pt1);
    bus.pixel_blend = 8'(bl);
    bus.s_valid     = 1'b1;
    @(posedge clk); #1;
    bus.s_valid     = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      if (bus.m_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic release_result();
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    check("m_valid_drop", int'(bus.m_valid), 0);
  endtask

  task automatic expect_result(input string tag, input int pt, input int pt1, input int bl,
                               input int mask, input int degen, input int clamp, input int lat_exp);
    int lat;
    start_tx(pt, pt1, bl);
    wait_result(lat);
    check({tag, "_lat"}, lat, lat_exp);
    check({tag, "_mask"}, int'(bus.mask_out), mask);
    check({tag, "_degen"}, int'(bus.degenerate), degen);
    check({tag, "_clamp"}, int'(bus.clamped), clamp);
    release_result();
  endtask

  task automatic sweep(input int n);
    for (int v = 0; v < n; v++) begin
      int pt, pt1, m, bl, num, den, trunc, est, rb, diff;
      int lat [6];
      pt  = int'($urandom_range(0, 255));
      pt1 = int'($urandom_range(0, 254));
      if (pt1 >= pt) pt1++;
      m   = int'($urandom_range(0, 255));
      bl  = (pt * m + pt1 * (255 - m) + 127) / 255;
      if (pt >= pt1) begin
        den = pt - pt1;
        num = bl - pt1;
      end else begin
        den = pt1 - pt;
        num = pt1 - bl;
      end
      trunc = (255 * num) / den;
      sw_pt    = 8'(pt);
      sw_pt1   = 8'(pt1);
      sw_bl    = 8'(bl);
      sw_valid = 1'b1;
      @(posedge clk); #1;
      sw_valid = 1'b0;
      for (int i = 0; i < 6; i++) lat[i] = -1;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++)
          if (lat[i] < 0 && sw_mvld[i]) lat[i] = c;
      end
      for (int i = 0; i < 6; i++) begin
        est  = int'(sw_mask[i]);
        rb   = (pt * est + pt1 * (255 - est) + 127) / 255;
        diff = rb - bl;
        check($sformatf("sw%0d_v%0d_lat", i, v), lat[i], 2 + 16 / sw_iter(i));
        check($sformatf("sw%0d_v%0d_roundtrip(pt=%0d,pt1=%0d,bl=%0d,est=%0d)", i, v, pt, pt1, bl, est),
              (diff >= -1 && diff <= 1) ? 1 : 0, 1);
        check($sformatf("sw%0d_v%0d_degen", i, v), int'(sw_deg[i]), 0);
        check($sformatf("sw%0d_v%0d_clamp", i, v), int'(sw_clp[i]), 0);
        if (i % 2 == 0) check($sformatf("sw%0d_v%0d_trunc", i, v), est, trunc);
      end
      sw_mready = 1'b1;
      @(posedge clk); #1;
      sw_mready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst             = 1'b1;
    bus.s_valid     = 1'b0;
    bus.m_ready     = 1'b0;
    bus.pixel_t     = 8'd0;
    bus.pixel_t1    = 8'd0;
    bus.pixel_blend = 8'd0;
    sw_valid  = 1'b0;
    sw_mready = 1'b0;
    sw_pt     = 8'd0;
    sw_pt1    = 8'd0;
    sw_bl     = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_s_ready", int'(bus.s_ready), 1);
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_mask", int'(bus.mask_out), 0);
    check("rst_degen", int'(bus.degenerate), 0);
    check("rst_clamp", int'(bus.clamped), 0);

    expect_result("mid",      200, 100, 150, 128, 0, 0, 18);
    expect_result("inv_mid",  100, 200, 150, 128, 0, 0, 18);
    expect_result("inv_zero", 100, 200, 200,   0, 0, 0, 18);
    expect_result("inv_full", 100, 200, 100, 255, 0, 0,  2);
    expect_result("degen",     77,  77,  77, 255, 1, 0,  2);
    expect_result("clamp_lo", 200, 100,  90,   0, 0, 1,  2);
    expect_result("clamp_hi", 200, 100, 210, 255, 0, 1,  2);

    // Result held under backpressure
    start_tx(200, 100, 150);
    wait_result(lat);
    check("bp_lat", lat, 18);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_m_valid", k), int'(bus.m_valid), 1);
      check($sformatf("bp_hold%0d_mask", k), int'(bus.mask_out), 128);
      check($sformatf("bp_hold%0d_s_ready", k), int'(bus.s_ready), 0);
    end
    release_result();

    // Inputs wiggled while dividing must not disturb the captured triple
    start_tx(10, 250, 100);
    for (int i = 0; i < 8; i++) begin
      bus.s_valid     = (i % 3 != 2);
      bus.pixel_t     = 8'(i + 1);
      bus.pixel_t1    = 8'(3 * i);
      bus.pixel_blend = 8'(7 + i);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    wait_result(lat);
    check("ign_lat", lat + 8, 18);
    check("ign_mask", int'(bus.mask_out), 159);
    release_result();

    // Reset during the seventh divide cycle
    start_tx(200, 100, 150);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_s_ready", int'(bus.s_ready), 1);
    check("mrst_m_valid", int'(bus.m_valid), 0);
    check("mrst_mask", int'(bus.mask_out), 0);
    check("mrst_degen", int'(bus.degenerate), 0);
    check("mrst_clamp", int'(bus.clamped), 0);
    rst = 1'b0;
    expect_result("post_rst", 200, 100, 150, 128, 0, 0, 18);

    sweep(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
